// File: rtl/note_sequencer.sv
// note_sequencer
//   Melody sequencer feeding the PWM sample player. Steps through a 16-entry
//   note memory and drives the player's pitch divider and a gate per note.
//   Note durations count tempo ticks from an internal prescaler. Playback is
//   one-shot or looped and is controlled with start/stop strobes.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   tick_period   one tempo tick every tick_period+1 clocks
//   wr_en/wr_addr/wr_data  note memory write port; data = {divider[11:0], d[3:0]}
//   last_idx      index of the final note in the sequence
//   loop          1 = wrap from last_idx back to entry 0
//   start, stop   single-cycle playback control strobes (stop wins)
//   divider       pitch divider (12'hFFF marks a rest)
//   gate          high while a non-rest note sounds
//   note_start    one-cycle pulse on the first cycle of each note
//   note_idx      index of the current note
//   playing       high whenever not idle
module note_sequencer #(
  parameter int TICK_WIDTH = 20,
  parameter int GAP_TICKS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TICK_WIDTH-1:0] tick_period,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [15:0]           wr_data,
  input  logic [3:0]            last_idx,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  output logic [11:0]           divider,
  output logic                  gate,
  output logic                  note_start,
  output logic [3:0]            note_idx,
  output logic                  playing
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [11:0] REST_DIV = 12'hFFF;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t                state;
  logic [TICK_WIDTH-1:0] prescaler;
  logic [3:0]            dur_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [15:0]           mem [16];

  logic       tick;
  logic       note_done;
  logic       gap_done;
  logic       advance;
  logic       at_last;
  logic       do_load;
  logic       do_finish;
  logic [3:0] load_idx;
  logic [15:0] entry;

  // Note memory: not reset, contents retained across rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Advance decision: with no gap, the note end itself is the advance point.
  always_comb begin
    tick      = (prescaler == '0);
    note_done = (state == PLAY) && tick && (dur_cnt == 4'd0);
    gap_done  = (state == GAP)  && tick && (gap_cnt == '0);
    advance   = (GAP_TICKS == 0) ? note_done : gap_done;
    at_last   = (note_idx == last_idx);
    do_load   = !stop && (((state == IDLE) && start) || (advance && !(at_last && !loop)));
    do_finish = !stop && advance && at_last && !loop;
    load_idx  = 4'd0;
    if (state != IDLE && !at_last) load_idx = note_idx + 4'd1;
    entry     = mem[load_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prescaler  <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      divider    <= '0;
      gate       <= 1'b0;
      note_start <= 1'b0;
      note_idx   <= '0;
      playing    <= 1'b0;
    end else begin
      note_start <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        gate    <= 1'b0;
        playing <= 1'b0;
      end else if (do_load) begin
        state      <= PLAY;
        note_idx   <= load_idx;
        divider    <= entry[15:4];
        gate       <= (entry[15:4] != REST_DIV);
        note_start <= 1'b1;
        playing    <= 1'b1;
        prescaler  <= tick_period;
        dur_cnt    <= entry[3:0];
      end else if (do_finish) begin
        state   <= IDLE;
        gate    <= 1'b0;
        playing <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (tick) begin
              prescaler <= tick_period;
              if (dur_cnt == 4'd0) begin
                // Only reachable with a nonzero gap; zero-gap ends take do_load/do_finish.
                state   <= GAP;
                gate    <= 1'b0;
                gap_cnt <= GAP_LOAD;
              end else begin
                dur_cnt <= dur_cnt - 4'd1;
              end
            end else begin
              prescaler <= prescaler - TICK_WIDTH'(1);
            end
          end
          GAP: begin
            if (tick) begin
              prescaler <= tick_period;
              gap_cnt   <= gap_cnt - GW'(1);
            end else begin
              prescaler <= prescaler - TICK_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer. Two instances share all inputs:
// u_gap uses GAP_TICKS=1, u_nogap uses GAP_TICKS=0.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] tick_period;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  last_idx;
  logic        loop;
  logic        start;
  logic        stop;

  logic [11:0] g_divider, n_divider;
  logic        g_gate, n_gate;
  logic        g_note_start, n_note_start;
  logic [3:0]  g_note_idx, n_note_idx;
  logic        g_playing, n_playing;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_sequencer #(.TICK_WIDTH(20), .GAP_TICKS(1)) u_gap (
    .clk(clk), .rst_n(rst_n), .tick_period(tick_period),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
    .divider(g_divider), .gate(g_gate), .note_start(g_note_start),
    .note_idx(g_note_idx), .playing(g_playing)
  );

  note_sequencer #(.TICK_WIDTH(20), .GAP_TICKS(0)) u_nogap (
    .clk(clk), .rst_n(rst_n), .tick_period(tick_period),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
    .divider(n_divider), .gate(n_gate), .note_start(n_note_start),
    .note_idx(n_note_idx), .playing(n_playing)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [11:0] dv, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = {dv, d};
    step();
    wr_en = 1'b0;
  endtask

  // Expected u_nogap output for loop program {200,d0},{FFF,d2},{300,d0}, tp=1
  function automatic logic [3:0] exp_idx(input int k);
    int p = k % 10;
    if (p < 2) return 4'd0;
    if (p < 8) return 4'd1;
    return 4'd2;
  endfunction

  function automatic logic [11:0] exp_div(input logic [3:0] i, input logic [11:0] div2);
    if (i == 4'd0) return 12'd200;
    if (i == 4'd1) return 12'hFFF;
    return div2;
  endfunction

  task automatic check_loop_cycle(input int k, input logic [11:0] div2);
    logic [3:0]  ei;
    logic [11:0] ed;
    logic        en;
    ei = exp_idx(k);
    ed = exp_div(ei, div2);
    en = ((k % 10) == 0) || ((k % 10) == 2) || ((k % 10) == 8);
    checks++;
    if (n_note_idx !== ei) begin
      errors++; $display("FAIL loop_idx k=%0d got %0d want %0d", k, n_note_idx, ei);
    end
    checks++;
    if (n_divider !== ed) begin
      errors++; $display("FAIL loop_div k=%0d got %0h want %0h", k, n_divider, ed);
    end
    checks++;
    if (n_gate !== (ei != 4'd1)) begin
      errors++; $display("FAIL loop_gate k=%0d got %0b want %0b", k, n_gate, ei != 4'd1);
    end
    checks++;
    if (n_note_start !== en) begin
      errors++; $display("FAIL loop_ns k=%0d got %0b want %0b", k, n_note_start, en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick_period = 20'd3; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    step(); step();
    checks++;
    if ({g_divider, g_gate, g_note_start, g_note_idx, g_playing} !== 19'd0) begin
      errors++; $display("FAIL reset_gap got %0h want 0", {g_divider, g_gate, g_note_start, g_note_idx, g_playing});
    end
    checks++;
    if ({n_divider, n_gate, n_note_start, n_note_idx, n_playing} !== 19'd0) begin
      errors++; $display("FAIL reset_nogap got %0h want 0", {n_divider, n_gate, n_note_start, n_note_idx, n_playing});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_one_shot();
    write_entry(4'd0, 12'd100, 4'd1);
    last_idx = 4'd0; loop = 1'b0; tick_period = 20'd3;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (g_divider !== 12'd100 || g_gate !== 1'b1 || g_note_start !== 1'b1 || g_playing !== 1'b1) begin
      errors++; $display("FAIL oneshot_load got div=%0d gate=%0b ns=%0b play=%0b want 100 1 1 1",
                         g_divider, g_gate, g_note_start, g_playing);
    end
    for (int c = 2; c <= 8; c++) begin
      step();
      checks++;
      if (g_gate !== 1'b1 || g_note_start !== 1'b0) begin
        errors++; $display("FAIL oneshot_gate c=%0d got gate=%0b ns=%0b want 1 0", c, g_gate, g_note_start);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (g_gate !== 1'b0 || g_playing !== 1'b1 || g_divider !== 12'd100) begin
        errors++; $display("FAIL oneshot_gap c=%0d got gate=%0b play=%0b div=%0d want 0 1 100",
                           c, g_gate, g_playing, g_divider);
      end
    end
    step();
    checks++;
    if (g_playing !== 1'b0 || g_divider !== 12'd100 || g_note_idx !== 4'd0 || g_gate !== 1'b0) begin
      errors++; $display("FAIL oneshot_end got play=%0b div=%0d idx=%0d gate=%0b want 0 100 0 0",
                         g_playing, g_divider, g_note_idx, g_gate);
    end
  endtask

  task automatic test_loop();
    write_entry(4'd0, 12'd200, 4'd0);
    write_entry(4'd1, 12'hFFF, 4'd2);
    write_entry(4'd2, 12'd300, 4'd0);
    last_idx = 4'd2; loop = 1'b1; tick_period = 20'd1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      check_loop_cycle(k, 12'd300);
    end
  endtask

  task automatic test_stop();
    // currently at loop cycle 19; advance into the middle of the rest note
    repeat (4) step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (n_gate !== 1'b0 || n_playing !== 1'b0 || n_note_start !== 1'b0 ||
        n_divider !== 12'hFFF || n_note_idx !== 4'd1) begin
      errors++; $display("FAIL stop_hold got gate=%0b play=%0b ns=%0b div=%0h idx=%0d want 0 0 0 fff 1",
                         n_gate, n_playing, n_note_start, n_divider, n_note_idx);
    end
    step();
    checks++;
    if (n_playing !== 1'b0 || n_note_idx !== 4'd1) begin
      errors++; $display("FAIL stop_idle got play=%0b idx=%0d want 0 1", n_playing, n_note_idx);
    end
    start = 1'b1; step(); start = 1'b0;
    check_loop_cycle(0, 12'd300);
  endtask

  task automatic test_start_ignored();
    stop = 1'b1; step(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++;
    if (n_playing !== 1'b0 || g_playing !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle got play=%0b/%0b want 0/0", n_playing, g_playing);
    end
    step();
    checks++;
    if (n_playing !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle2 got play=%0b want 0", n_playing);
    end
    start = 1'b1; step(); start = 1'b0;
    check_loop_cycle(0, 12'd300);
    step();
    start = 1'b1;
    check_loop_cycle(1, 12'd300);
    step(); start = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      if (k > 2) step();
      check_loop_cycle(k, 12'd300);
    end
  endtask

  task automatic test_rewrite();
    // at loop cycle 8: entry 2 is playing
    write_entry(4'd2, 12'd400, 4'd0);
    check_loop_cycle(9, 12'd300);
    for (int k = 10; k <= 19; k++) begin
      step();
      check_loop_cycle(k, 12'd400);
    end
  endtask

  task automatic test_reset_gap();
    stop = 1'b1; step(); stop = 1'b0;
    last_idx = 4'd0; loop = 1'b0; tick_period = 20'd3;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (g_divider !== 12'd200 || g_gate !== 1'b1 || g_note_start !== 1'b1) begin
      errors++; $display("FAIL rgap_load got div=%0d gate=%0b ns=%0b want 200 1 1",
                         g_divider, g_gate, g_note_start);
    end
    repeat (4) step();
    checks++;
    if (g_gate !== 1'b0 || g_playing !== 1'b1 || g_divider !== 12'd200) begin
      errors++; $display("FAIL rgap_in_gap got gate=%0b play=%0b div=%0d want 0 1 200",
                         g_gate, g_playing, g_divider);
    end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++;
    if ({g_divider, g_gate, g_note_start, g_note_idx, g_playing} !== 19'd0) begin
      errors++; $display("FAIL rgap_reset got %0h want 0", {g_divider, g_gate, g_note_start, g_note_idx, g_playing});
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (g_divider !== 12'd200 || g_gate !== 1'b1 || g_note_start !== 1'b1 ||
        g_note_idx !== 4'd0 || g_playing !== 1'b1) begin
      errors++; $display("FAIL rgap_retained got div=%0d gate=%0b ns=%0b idx=%0d play=%0b want 200 1 1 0 1",
                         g_divider, g_gate, g_note_start, g_note_idx, g_playing);
    end
    repeat (8) step();
    checks++;
    if (g_playing !== 1'b0 || g_divider !== 12'd200) begin
      errors++; $display("FAIL rgap_end got play=%0b div=%0d want 0 200", g_playing, g_divider);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_stop();
    test_start_ignored();
    test_rewrite();
    test_reset_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
